relu_pool: RTL and testbench

Post-convolution stage directly downstream of the PE array. Consumes the per-pixel accumulated output-feature-map stream (`data_out` of the last PE after channel accumulation) for one output channel in raster order. Adds a per-channel bias, applies ReLU, and performs 2x2 / stride-2 max pooling. Emits the pooled map in raster order to the ofmap write-back path.

---
 rtl/relu_pool.sv | 155 +++++++++++++++
 tb/tb_relu_pool.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool.sv
// Bias + ReLU + 2x2/stride-2 max pooling over one raster-ordered output channel.
// Half-row buffer rb holds pairwise column maxima of the even row until the odd row arrives.
module relu_pool #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WIDTH  = 28
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [4:0]            ofmap_width,
  input  logic [4:0]            ofmap_height,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int RB_DEPTH = MAX_WIDTH / 2;
  localparam int RB_AW    = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            width_q, width_d;
  logic [4:0]            height_q, height_d;
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic [4:0]            col_q, col_d;
  logic [4:0]            row_q, row_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] rb_q [RB_DEPTH];

  logic                  accept;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] x;
  logic                  last_col, last_row;
  logic                  col_tail, row_tail;
  logic [RB_AW-1:0]      rb_idx;
  logic [DATA_WIDTH-1:0] rb_rd;
  logic                  rb_we;
  logic [DATA_WIDTH-1:0] rb_wdata;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    bias_d      = bias_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    h_d         = h_q;
    rb_we       = 1'b0;
    rb_wdata    = '0;

    accept   = (state_q == S_RUN) && in_valid;
    sum      = in_data + bias_q;
    x        = sum[DATA_WIDTH-1] ? '0 : sum;
    last_col = (col_q == width_q - 5'd1);
    last_row = (row_q == height_q - 5'd1);
    // Trailing column/row of an odd dimension has no partner and is dropped.
    col_tail = width_q[0] && last_col;
    row_tail = height_q[0] && last_row;
    rb_idx   = RB_AW'(col_q >> 1);
    rb_rd    = rb_q[rb_idx];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d  = ofmap_width;
          height_d = ofmap_height;
          bias_d   = bias;
          col_d    = '0;
          row_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? 5'd0 : row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
          if (last_col && last_row) state_d = S_DONE;

          if (!col_tail && !row_tail) begin
            case ({row_q[0], col_q[0]})
              2'b00: h_d = x;
              2'b01: begin
                rb_we    = 1'b1;
                rb_wdata = smax(h_q, x);
              end
              2'b10: h_d = smax(rb_rd, x);
              default: begin
                out_valid_d = 1'b1;
                out_data_d  = smax(h_q, x);
              end
            endcase
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      bias_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      bias_q      <= bias_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Datapath storage is always written before it is read within a map.
  always_ff @(posedge clk) begin
    h_q <= h_d;
    if (rb_we) rb_q[rb_idx] <= rb_wdata;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_relu_pool.sv
// Directed and random checks of relu_pool against a whole-map pooling model.
module tb_relu_pool;

  logic        clk;
  logic        srstn;
  logic        start;
  logic [4:0]  ofmap_width;
  logic [4:0]  ofmap_height;
  logic [31:0] bias;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] stim_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] lit_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  relu_pool #(.DATA_WIDTH(32), .MAX_WIDTH(28)) dut (
    .clk          (clk),
    .srstn        (srstn),
    .start        (start),
    .ofmap_width  (ofmap_width),
    .ofmap_height (ofmap_height),
    .bias         (bias),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every emitted sample must match the model, and any literal expectation.
  always @(negedge clk) begin
    if (srstn && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
      if (lit_q.size() > 0) chk("out_literal", out_data, lit_q.pop_front());
    end
  end

  // Model: relu(in + bias) over the whole map, then max over each full 2x2 window.
  task automatic build_expected(input int w, input int h, input logic [31:0] b);
    logic [31:0] xv [28][28];
    logic [31:0] s;
    logic [31:0] m;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        s = stim_q[r*w + c] + b;
        xv[r][c] = ($signed(s) < 0) ? 32'd0 : s;
      end
    end
    for (int pr = 0; pr < h/2; pr++) begin
      for (int pc = 0; pc < w/2; pc++) begin
        m = 32'd0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if ($signed(xv[2*pr+dr][2*pc+dc]) > $signed(m)) m = xv[2*pr+dr][2*pc+dc];
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic start_map(input int w, input int h, input logic [31:0] b);
    @(posedge clk); #1;
    start        = 1'b1;
    ofmap_width  = w[4:0];
    ofmap_height = h[4:0];
    bias         = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic drive_beats(input int n, input int gap_pct, input bit mid_start);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        start    = mid_start ? 1'($urandom_range(1)) : 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      start    = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Returns inside the done cycle so a following start_map lands with no bubble.
  task automatic run_map(input int w, input int h, input logic [31:0] b,
                         input int gap_pct, input bit mid_start);
    build_expected(w, h, b);
    start_map(w, h, b);
    drive_beats(w*h, gap_pct, mid_start);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("valid_with_done", {31'd0, out_valid}, {31'd0, (w % 2 == 0) && (h % 2 == 0)});
    #1;
    chk("all_outputs_seen", exp_q.size(), 32'd0);
    chk("all_literals_seen", lit_q.size(), 32'd0);
  endtask

  initial begin
    srstn        = 1'b0;
    start        = 1'b0;
    ofmap_width  = '0;
    ofmap_height = '0;
    bias         = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    repeat (3) @(posedge clk);
    #1 srstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // 4x4 ramp 1..16
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back((i + 1) << 16);
    lit_q = '{32'h0006_0000, 32'h0008_0000, 32'h000E_0000, 32'h0010_0000};
    run_map(4, 4, 32'd0, 0, 1'b0);

    // 4x2 with negative bias
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back((i + 1) << 16);
    lit_q = '{32'h0003_0000, 32'h0005_0000};
    run_map(4, 2, 32'hFFFD_0000, 0, 1'b0);

    // All negative 2x2
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(-((i + 1) << 16));
    lit_q = '{32'h0000_0000};
    run_map(2, 2, 32'd0, 0, 1'b0);

    // 5x5 raster index: trailing column and row dropped
    stim_q.delete();
    for (int i = 0; i < 25; i++) stim_q.push_back(i << 16);
    lit_q = '{32'h0006_0000, 32'h0008_0000, 32'h0010_0000, 32'h0012_0000};
    run_map(5, 5, 32'd0, 0, 1'b0);

    // Bias add wraps negative and clamps to zero
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(32'h0002_0000);
    lit_q = '{32'h0000_0000};
    run_map(2, 2, 32'h7FFF_0000, 0, 1'b0);

    // Reset in the middle of a 4x4 after 5 beats
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back((i + 1) << 16);
    start_map(4, 4, 32'd0);
    drive_beats(5, 0, 1'b0);
    srstn = 1'b0;
    @(posedge clk); #1;
    srstn = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_no_pending", exp_q.size(), 32'd0);
    lit_q = '{32'h0006_0000, 32'h0008_0000, 32'h000E_0000, 32'h0010_0000};
    run_map(4, 4, 32'd0, 0, 1'b0);

    // Full 28x28 random with gaps and ignored mid-map starts, then back-to-back map
    stim_q.delete();
    for (int i = 0; i < 28*28; i++) stim_q.push_back($urandom);
    run_map(28, 28, $urandom, 30, 1'b1);
    stim_q.delete();
    for (int i = 0; i < 24; i++) stim_q.push_back($urandom);
    run_map(6, 4, $urandom, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
